// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the NoC port arbiter.
//   arb_state_e  - arbiter FSM state encoding (IDLE / LOCK)
//   N_PORTS_DEF  - default requester count
//   tail_bit()   - bit position of the tail flag within a flit (MSB)
//   idx_width()  - width of a port index, never less than 1 bit
package noc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int N_PORTS_DEF = 4;

  function automatic int tail_bit(input int width);
    return width - 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// rr_grant_picker: combinational round-robin search.
//   req     [N-1:0]  - request vector (1 = port wants service)
//   ptr     [IW-1:0] - last served port; search starts at ptr+1 mod N
//   winner  [IW-1:0] - first requesting port found (0 when none)
//   any_req          - at least one request is present
module rr_grant_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  function automatic int wrap_idx(input int p, input int k);
    int s;
    s = p + k;
    if (s >= N) s = s - N;
    return s;
  endfunction

  // Walk offsets from farthest to nearest so the nearest hit after ptr
  // is the last one written and therefore wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && (i == wrap_idx(int'(ptr), k))) begin
          winner  = IW'(i);
          any_req = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter: round-robin arbiter moving flits from N_PORTS input
// buffers onto one output link.
//   clk, rst   - clock; asynchronous active-high reset
//   empty      - per-buffer empty flag (0 = flit available)
//   buf_data   - buffer heads, port i at [i*bit_width +: bit_width]
//   out_full   - downstream backpressure, blocks every transfer
//   consume    - combinational one-hot pop strobe to the buffers
//   data_out   - registered flit, valid_out marks the cycle after a pop
//   grant_id   - registered index of the port that supplied data_out
//   busy       - a multi-flit packet currently holds the grant
// Build option: define ARB_PKT_LOCK_EN for wormhole packet locking (grant
// held from header through tail flit). Without it arbitration is per flit,
// the tail bit is ignored and busy stays 0.
module rr_port_arbiter import noc_pkg::*; #(
  parameter int N_PORTS   = N_PORTS_DEF,
  parameter int bit_width = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORTS-1:0]              empty,
  input  logic [N_PORTS*bit_width-1:0]    buf_data,
  input  logic                            out_full,
  output logic [N_PORTS-1:0]              consume,
  output logic [bit_width-1:0]            data_out,
  output logic                            valid_out,
  output logic [idx_width(N_PORTS)-1:0]   grant_id,
  output logic                            busy
);

  localparam int IW = idx_width(N_PORTS);
  localparam int TB = tail_bit(bit_width);

  arb_state_e           state;
  logic [IW-1:0]        ptr, winner, sel, owner;
  logic                 any_req, pop, owner_rdy;
  logic [N_PORTS-1:0]   req;
  logic [bit_width-1:0] sel_flit;

  assign req = ~empty;

  rr_grant_picker #(.N(N_PORTS), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef ARB_PKT_LOCK_EN
  arb_state_e state_nxt;

  // State register; owner is captured when a header (non-tail) flit wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pop && !sel_flit[TB]) owner <= winner;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pop && !sel_flit[TB]) state_nxt = ST_LOCK;
      ST_LOCK: if (pop &&  sel_flit[TB]) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end
`else
  assign state = ST_IDLE;
  assign owner = '0;
`endif

  // Output decode: who is served this cycle and the pop strobe.
  always_comb begin
    sel       = winner;
    pop       = 1'b0;
    busy      = 1'b0;
    owner_rdy = 1'b0;
    for (int i = 0; i < N_PORTS; i++)
      if (owner == IW'(i)) owner_rdy = ~empty[i];
    case (state)
      ST_IDLE: pop = any_req & ~out_full;
      ST_LOCK: begin
        sel  = owner;
        pop  = owner_rdy & ~out_full;
        busy = 1'b1;
      end
      default: ;
    endcase
    if (rst) pop = 1'b0;
    consume  = '0;
    sel_flit = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (sel == IW'(i)) begin
        consume[i] = pop;
        sel_flit   = buf_data[i*bit_width +: bit_width];
      end
    end
  end

  // ptr only advances on IDLE grants; inside a packet it already names the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= IW'(N_PORTS - 1);
      data_out  <= '0;
      valid_out <= 1'b0;
      grant_id  <= '0;
    end else begin
      valid_out <= pop;
      if (pop) begin
        data_out <= sel_flit;
        grant_id <= sel;
        if (state == ST_IDLE) ptr <= winner;
      end
    end
  end

endmodule
